ym_timers: RTL and testbench

YM2610 Timer A / Timer B block. It sits directly downstream of the YM2610 register file. It consumes the timer load values, the timer config word and the run set/clear pulses, and produces the two timer status flags, the Z80 interrupt request and per-timer overflow strobes. The ADPCM/FM stages use those strobes, for example for CSM.

---
 rtl/ym_timers_if.sv | 30 +++
 rtl/ym_timers.sv | 136 +++++++++++++
 tb/tb_ym_timers.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ym_timers_if.sv
// ym_timers_if: register-file side bundle for the YM2610 timer block.
// Load values, config and run pulses in; flags, strobes and run state out.
interface ym_timers_if;
    logic [9:0] TA_LOAD;
    logic [7:0] TB_LOAD;
    logic [5:0] CONFIG;
    logic       set_run_A;
    logic       clr_run_A;
    logic       set_run_B;
    logic       clr_run_B;
    logic       FLAG_A;
    logic       FLAG_B;
    logic       nIRQ;
    logic       TA_OVF;
    logic       TB_OVF;
    logic       RUN_A;
    logic       RUN_B;

    modport master (
        output TA_LOAD, TB_LOAD, CONFIG,
        output set_run_A, clr_run_A, set_run_B, clr_run_B,
        input  FLAG_A, FLAG_B, nIRQ, TA_OVF, TB_OVF, RUN_A, RUN_B
    );

    modport slave (
        input  TA_LOAD, TB_LOAD, CONFIG,
        input  set_run_A, clr_run_A, set_run_B, clr_run_B,
        output FLAG_A, FLAG_B, nIRQ, TA_OVF, TB_OVF, RUN_A, RUN_B
    );
endinterface

// File: rtl/ym_timers.sv
// ym_timers: YM2610 Timer A / Timer B with free-running prescaler,
// overflow flags, IRQ and one-cycle overflow strobes.
module ym_timers #(
    parameter int PRESCALE = 72,
    parameter int TB_DIV   = 16
) (
    input  logic        PHI_M,
    input  logic        nRESET,
    ym_timers_if.slave  bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(TB_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(TB_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick_a, tick_b;

    logic [9:0] cnt_a_q, cnt_a_d;
    logic [7:0] cnt_b_q, cnt_b_d;
    logic       run_a_q, run_a_d;
    logic       run_b_q, run_b_d;
    logic       ovf_a_q, ovf_a_d;
    logic       ovf_b_q, ovf_b_d;
    logic       flag_a_q, flag_a_d;
    logic       flag_b_q, flag_b_d;

    // Load pulses in CONFIG[1:0] are deliberately ignored.
    logic unused_cfg;
    assign unused_cfg = ^bus.CONFIG[1:0];

    // Free-running prescaler and Timer B divider; run/load never touch them.
    always_comb begin
        tick_a = (pre_q == PRE_MAX);
        tick_b = tick_a && (div_q == DIV_MAX);
        pre_d  = tick_a ? '0 : pre_q + 1'b1;
        div_d  = div_q;
        if (tick_a) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        end
    end

    // Timer A: start reloads (no count that edge), stop holds, else count.
    always_comb begin
        cnt_a_d = cnt_a_q;
        run_a_d = run_a_q;
        ovf_a_d = 1'b0;
        if (bus.set_run_A && !run_a_q) begin
            cnt_a_d = bus.TA_LOAD;
            run_a_d = 1'b1;
        end else if (bus.clr_run_A && !bus.set_run_A) begin
            run_a_d = 1'b0;
        end else if (run_a_q && tick_a) begin
            if (cnt_a_q == 10'd1023) begin
                cnt_a_d = bus.TA_LOAD;
                ovf_a_d = 1'b1;
            end else begin
                cnt_a_d = cnt_a_q + 10'd1;
            end
        end
    end

    // Timer B: same control as A, clocked by the divided tick.
    always_comb begin
        cnt_b_d = cnt_b_q;
        run_b_d = run_b_q;
        ovf_b_d = 1'b0;
        if (bus.set_run_B && !run_b_q) begin
            cnt_b_d = bus.TB_LOAD;
            run_b_d = 1'b1;
        end else if (bus.clr_run_B && !bus.set_run_B) begin
            run_b_d = 1'b0;
        end else if (run_b_q && tick_b) begin
            if (cnt_b_q == 8'd255) begin
                cnt_b_d = bus.TB_LOAD;
                ovf_b_d = 1'b1;
            end else begin
                cnt_b_d = cnt_b_q + 8'd1;
            end
        end
    end

    // Flags: a qualified overflow beats a same-edge clear so no event is lost.
    always_comb begin
        flag_a_d = flag_a_q;
        flag_b_d = flag_b_q;
        if (bus.CONFIG[4]) begin
            flag_a_d = 1'b0;
        end
        if (bus.CONFIG[5]) begin
            flag_b_d = 1'b0;
        end
        if (ovf_a_d && bus.CONFIG[2]) begin
            flag_a_d = 1'b1;
        end
        if (ovf_b_d && bus.CONFIG[3]) begin
            flag_b_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge PHI_M) begin
        if (!nRESET) begin
            pre_q    <= '0;
            div_q    <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            run_a_q  <= 1'b0;
            run_b_q  <= 1'b0;
            ovf_a_q  <= 1'b0;
            ovf_b_q  <= 1'b0;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            div_q    <= div_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            run_a_q  <= run_a_d;
            run_b_q  <= run_b_d;
            ovf_a_q  <= ovf_a_d;
            ovf_b_q  <= ovf_b_d;
            flag_a_q <= flag_a_d;
            flag_b_q <= flag_b_d;
        end
    end

    assign bus.FLAG_A = flag_a_q;
    assign bus.FLAG_B = flag_b_q;
    assign bus.nIRQ   = ~(flag_a_q | flag_b_q);
    assign bus.TA_OVF = ovf_a_q;
    assign bus.TB_OVF = ovf_b_q;
    assign bus.RUN_A  = run_a_q;
    assign bus.RUN_B  = run_b_q;
endmodule

// File: tb/tb_ym_timers.sv
// tb_ym_timers: scoreboard bench for ym_timers.
// Predicted strobe times are queued at start and matched on each strobe.
module tb_ym_timers;
    localparam int PRE = 72;
    localparam int DIV = 16;
    localparam int TBP = PRE * DIV;

    logic PHI_M = 1'b0;
    logic nRESET = 1'b0;

    ym_timers_if bus ();

    ym_timers #(.PRESCALE(PRE), .TB_DIV(DIV)) dut (
        .PHI_M  (PHI_M),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 PHI_M = ~PHI_M;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned edge_n = 0;
    int unsigned qa[$];
    int unsigned qb[$];
    int unsigned ea, eb;
    int na = 0;
    int nb = 0;
    bit run_a_m = 0;
    bit run_b_m = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge index since reset release; mirrors the prescaler phase.
    always @(posedge PHI_M) begin
        if (!nRESET) edge_n <= 0;
        else edge_n <= edge_n + 1;
    end

    // Strobe monitor: stamp = overflow edge index + 1.
    always @(negedge PHI_M) begin
        if (nRESET) begin
            if (bus.TA_OVF === 1'b1) begin
                if (qa.size() == 0) check("ta_unexpected", {31'b0, bus.TA_OVF}, 0);
                else begin
                    ea = qa.pop_front();
                    check("ta_time", edge_n, ea);
                end
            end
            if (bus.TB_OVF === 1'b1) begin
                if (qb.size() == 0) check("tb_unexpected", {31'b0, bus.TB_OVF}, 0);
                else begin
                    eb = qb.pop_front();
                    check("tb_time", edge_n, eb);
                end
            end
        end
    end

    task automatic sched_a(input int unsigned s, input int l, input int n);
        int unsigned t = s + 1;
        while (t % PRE != PRE - 1) t++;
        t = t + PRE * (1023 - l);
        for (int k = 0; k < n; k++) qa.push_back(t + k * PRE * (1024 - l) + 1);
    endtask

    task automatic sched_b(input int unsigned s, input int l, input int n);
        int unsigned t = s + 1;
        while (t % TBP != TBP - 1) t++;
        t = t + TBP * (255 - l);
        for (int k = 0; k < n; k++) qb.push_back(t + k * TBP * (256 - l) + 1);
    endtask

    task automatic pulse(input bit sa, input bit ca, input bit sb, input bit cb);
        int unsigned s;
        @(negedge PHI_M);
        bus.set_run_A = sa;
        bus.clr_run_A = ca;
        bus.set_run_B = sb;
        bus.clr_run_B = cb;
        s = edge_n;
        if (sa && !run_a_m) begin
            sched_a(s, int'(bus.TA_LOAD), na);
            run_a_m = 1;
        end else if (ca && !sa) begin
            while (qa.size() > 0 && qa[$] >= s + 1) void'(qa.pop_back());
            run_a_m = 0;
        end
        if (sb && !run_b_m) begin
            sched_b(s, int'(bus.TB_LOAD), nb);
            run_b_m = 1;
        end else if (cb && !sb) begin
            while (qb.size() > 0 && qb[$] >= s + 1) void'(qb.pop_back());
            run_b_m = 0;
        end
        @(negedge PHI_M);
        bus.set_run_A = 0;
        bus.clr_run_A = 0;
        bus.set_run_B = 0;
        bus.clr_run_B = 0;
    endtask

    task automatic cfg_pulse(input logic [5:0] m);
        @(negedge PHI_M);
        bus.CONFIG = bus.CONFIG | m;
        @(negedge PHI_M);
        bus.CONFIG = bus.CONFIG & ~m;
    endtask

    task automatic wait_q(input string tag, input bit b, input int target,
                          input int budget);
        int left = budget;
        while (((b ? qb.size() : qa.size()) > target) && left > 0) begin
            @(negedge PHI_M);
            left--;
        end
        check(tag, b ? qb.size() : qa.size(), target);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PHI_M);
    endtask

    initial begin
        int left;
        int tgt;
        bus.TA_LOAD   = '0;
        bus.TB_LOAD   = '0;
        bus.CONFIG    = '0;
        bus.set_run_A = 0;
        bus.clr_run_A = 0;
        bus.set_run_B = 0;
        bus.clr_run_B = 0;
        nRESET = 0;

        repeat (3) @(negedge PHI_M);
        check("rst_flag_a", bus.FLAG_A, 0);
        check("rst_flag_b", bus.FLAG_B, 0);
        check("rst_nirq", bus.nIRQ, 1);
        check("rst_run_a", bus.RUN_A, 0);
        check("rst_run_b", bus.RUN_B, 0);
        check("rst_ta_ovf", bus.TA_OVF, 0);
        check("rst_tb_ovf", bus.TB_OVF, 0);
        nRESET = 1;
        idle(2000);

        bus.CONFIG  = 6'b000100;
        bus.TA_LOAD = 10'd1023;
        na = 6;
        pulse(1, 0, 0, 0);
        check("a_running", bus.RUN_A, 1);
        wait_q("a1023_first", 0, 5, 200);
        check("a1023_flag", bus.FLAG_A, 1);
        check("a1023_nirq", bus.nIRQ, 0);
        wait_q("a1023_train", 0, 0, 600);
        pulse(0, 1, 0, 0);
        check("a_stopped", bus.RUN_A, 0);
        cfg_pulse(6'b010000);
        check("a_flag_clr", bus.FLAG_A, 0);
        check("a_nirq_clr", bus.nIRQ, 1);

        bus.TA_LOAD = 10'd1020;
        na = 4;
        pulse(1, 0, 0, 0);
        wait_q("a1020_first", 0, 3, 600);
        check("a1020_flag", bus.FLAG_A, 1);
        cfg_pulse(6'b010000);
        check("a1020_clr", bus.FLAG_A, 0);
        left = 400;
        while (qa.size() > 0 && edge_n != qa[0] - 1 && left > 0) begin
            @(negedge PHI_M);
            left--;
        end
        bus.CONFIG[4] = 1'b1;
        @(negedge PHI_M);
        bus.CONFIG[4] = 1'b0;
        check("a_clr_vs_ovf", bus.FLAG_A, 1);
        wait_q("a1020_train", 0, 0, 900);
        pulse(0, 1, 0, 0);
        cfg_pulse(6'b010000);

        bus.CONFIG  = 6'b000000;
        bus.TB_LOAD = 8'd254;
        nb = 3;
        pulse(0, 0, 1, 0);
        wait_q("b254_first", 1, 2, 3600);
        check("b_flag_off", bus.FLAG_B, 0);
        check("b_nirq_off", bus.nIRQ, 1);
        bus.CONFIG = 6'b001000;
        wait_q("b254_second", 1, 1, 2400);
        check("b_flag_on", bus.FLAG_B, 1);
        check("b_nirq_on", bus.nIRQ, 0);
        wait_q("b254_third", 1, 0, 2400);
        pulse(0, 0, 0, 1);
        check("b_stopped", bus.RUN_B, 0);
        cfg_pulse(6'b100000);
        check("b_flag_clr", bus.FLAG_B, 0);
        bus.CONFIG = 6'b000000;

        bus.TA_LOAD = 10'd1000;
        na = 50;
        pulse(1, 0, 0, 0);
        wait_q("a1000_first", 0, 49, 1800);
        idle(700);
        pulse(0, 1, 0, 0);
        check("a1000_stop", bus.RUN_A, 0);
        idle(5000);
        na = 3;
        pulse(1, 0, 0, 0);
        wait_q("a1000_restart", 0, 2, 1800);
        idle(500);
        pulse(1, 0, 0, 0);
        wait_q("a1000_no_reload", 0, 0, 3600);
        pulse(0, 1, 0, 0);

        bus.TA_LOAD = 10'd1023;
        bus.TB_LOAD = 8'd255;
        bus.CONFIG  = 6'b001100;
        na = 100;
        nb = 10;
        pulse(1, 0, 1, 0);
        wait_q("ab_b_first", 1, 9, 1300);
        tgt = qa.size() - 1;
        wait_q("ab_a_sync", 0, tgt, 100);
        check("ab_flag_a", bus.FLAG_A, 1);
        check("ab_flag_b", bus.FLAG_B, 1);
        check("ab_nirq", bus.nIRQ, 0);
        @(negedge PHI_M);
        nRESET = 0;
        qa.delete();
        qb.delete();
        run_a_m = 0;
        run_b_m = 0;
        @(negedge PHI_M);
        check("mid_rst_run_a", bus.RUN_A, 0);
        check("mid_rst_run_b", bus.RUN_B, 0);
        check("mid_rst_flag_a", bus.FLAG_A, 0);
        check("mid_rst_flag_b", bus.FLAG_B, 0);
        check("mid_rst_nirq", bus.nIRQ, 1);
        check("mid_rst_ta_ovf", bus.TA_OVF, 0);
        check("mid_rst_tb_ovf", bus.TB_OVF, 0);
        nRESET = 1;
        idle(3000);
        check("post_rst_run_a", bus.RUN_A, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
